// File: rtl/enigma_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a single-entry valid/ready holding register.
// States: IDLE wait for low | START half-bit check | DATA 8 bits | STOP stop check | WAIT_HIGH wait for line release
`timescale 1ns/1ps
module enigma_uart_rx #(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk_100mhz,
  input  logic       ext_rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_TC_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_TC_LOAD = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  logic [1:0]    sync_q;
  logic          rx_s;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q;
  logic          valid_q, frame_err_q, overrun_q;
  logic          byte_done, stop_bad;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk_100mhz or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], uart_rx};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  // Timing runs on a down-counter: each phase loads its length minus one and acts at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    byte_done = 1'b0;
    stop_bad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) begin
          state_d = S_START;
          cnt_d   = HALF_TC_LOAD;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rx_s) begin
            state_d = S_DATA;
            cnt_d   = BIT_TC_LOAD;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = BIT_TC_LOAD;
          if (idx_q == 3'd7) state_d = S_STOP;
          else               idx_d   = idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          if (rx_s) begin
            byte_done = 1'b1;
            state_d   = S_IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = S_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_WAIT_HIGH: begin
        cnt_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A completing byte may replace the held one only when the consumer takes it in the same cycle.
  always_ff @(posedge clk_100mhz or negedge ext_rst_n) begin
    if (!ext_rst_n) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= stop_bad;
      overrun_q   <= 1'b0;
      if (byte_done) begin
        if (!valid_q || rx_ready) begin
          data_q  <= shift_q;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign rx_busy   = (state_q != S_IDLE);

endmodule

// File: tb/tb_enigma_uart_rx.sv
// Scoreboard bench for enigma_uart_rx: bytes are queued as they are sent on the line and
// checked by a monitor at each accepted handshake; error pulses are counted against expectations.
`timescale 1ns/1ps
module tb_enigma_uart_rx;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int CPB      = CLK_HZ / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int S_SAMPLE = HALF + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       line = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid, fe, ov, busy;

  always #10 clk = ~clk;

  enigma_uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk_100mhz(clk),
    .ext_rst_n (rst_n),
    .uart_rx   (line),
    .rx_data   (data),
    .rx_valid  (valid),
    .rx_ready  (ready),
    .frame_err (fe),
    .overrun   (ov),
    .rx_busy   (busy)
  );

  int         n_checks = 0;
  int         n_fail = 0;
  int         fe_cnt = 0, ov_cnt = 0, exp_fe = 0, exp_ov = 0, acc_cnt = 0;
  logic       fe_prev = 1'b0, ov_prev = 1'b0;
  logic [7:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (valid && ready) begin
        acc_cnt++;
        check("sb_pending", {31'd0, sb.size() > 0}, 32'd1);
        if (sb.size() > 0) check("rx_data", {24'd0, data}, {24'd0, sb.pop_front()});
      end
      if (fe) begin
        fe_cnt++;
        check("frame_err_one_cycle", {31'd0, fe_prev}, 32'd0);
      end
      if (ov) begin
        ov_cnt++;
        check("overrun_one_cycle", {31'd0, ov_prev}, 32'd0);
      end
    end
    fe_prev = fe;
    ov_prev = ov;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    line = v;
    cycles(n);
  endtask

  task automatic send(input logic [7:0] b, input int bp, input logic stop);
    drive(1'b0, bp);
    for (int i = 0; i < 8; i++) drive(b[i], bp);
    drive(stop, bp);
    line = 1'b1;
  endtask

  task automatic pulse_ready();
    ready = 1'b1;
    cycles(1);
    ready = 1'b0;
  endtask

  task automatic summary();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    summary();
    $fatal(1, "watchdog");
  end

  initial begin
    int drops;
    int acc_before;
    cycles(5);
    check("reset_rx_data", {24'd0, data}, 32'h00);
    check("reset_rx_valid", {31'd0, valid}, 32'd0);
    check("reset_frame_err", {31'd0, fe}, 32'd0);
    check("reset_overrun", {31'd0, ov}, 32'd0);
    check("reset_rx_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    cycles(3);

    // single byte with exact completion timing
    sb.push_back(8'h41);
    fork
      send(8'h41, CPB, 1'b1);
      begin
        cycles(2 + S_SAMPLE);
        check("valid_before_stop_edge", {31'd0, valid}, 32'd0);
        cycles(1);
        check("valid_after_stop_edge", {31'd0, valid}, 32'd1);
        check("data_after_stop_edge", {24'd0, data}, 32'h41);
      end
    join
    cycles(5);
    pulse_ready();
    check("valid_cleared_by_ready", {31'd0, valid}, 32'd0);
    check("fe_count_single", fe_cnt, exp_fe);
    check("ov_count_single", ov_cnt, exp_ov);

    // glitch shorter than half a bit
    drive(1'b0, 10);
    drive(1'b1, CPB);
    check("glitch_busy", {31'd0, busy}, 32'd0);
    check("glitch_valid", {31'd0, valid}, 32'd0);
    sb.push_back(8'hA5);
    send(8'hA5, CPB, 1'b1);
    cycles(2);
    pulse_ready();

    // framing error followed by a held-low line
    send(8'h3C, CPB, 1'b0);
    exp_fe++;
    drive(1'b0, CPB);
    check("wait_high_busy", {31'd0, busy}, 32'd1);
    check("frame_err_no_valid", {31'd0, valid}, 32'd0);
    drive(1'b0, CPB);
    drive(1'b1, 4);
    check("wait_high_released", {31'd0, busy}, 32'd0);
    check("fe_count_frame", fe_cnt, exp_fe);
    sb.push_back(8'h5A);
    send(8'h5A, CPB, 1'b1);
    cycles(2);
    pulse_ready();

    // overrun: second byte dropped while the first is held
    sb.push_back(8'h11);
    send(8'h11, CPB, 1'b1);
    send(8'h22, CPB, 1'b1);
    exp_ov++;
    cycles(2);
    check("ov_count_overrun", ov_cnt, exp_ov);
    check("overrun_held_data", {24'd0, data}, 32'h11);
    check("overrun_held_valid", {31'd0, valid}, 32'd1);
    pulse_ready();
    check("overrun_drained", {31'd0, valid}, 32'd0);

    // ready coincides with the completion of the second byte
    sb.push_back(8'h11);
    sb.push_back(8'h22);
    send(8'h11, CPB, 1'b1);
    drops = 0;
    fork
      send(8'h22, CPB, 1'b1);
      begin
        cycles(2 + S_SAMPLE);
        ready = 1'b1;
        cycles(1);
        ready = 1'b0;
      end
      begin
        repeat (10 * CPB - 2) begin
          @(negedge clk);
          if (!valid) drops++;
        end
      end
    join
    check("valid_continuous", drops, 0);
    check("ov_count_simul", ov_cnt, exp_ov);
    check("simul_data", {24'd0, data}, 32'h22);
    pulse_ready();

    // reset in the middle of data bit 4 of 0xFF
    drive(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive(1'b1, CPB);
    drive(1'b1, HALF);
    rst_n = 1'b0;
    #1;
    check("midrst_data", {24'd0, data}, 32'h00);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_fe", {31'd0, fe}, 32'd0);
    check("midrst_ov", {31'd0, ov}, 32'd0);
    line = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    acc_before = acc_cnt;
    sb.push_back(8'h07);
    send(8'h07, CPB, 1'b1);
    cycles(2);
    pulse_ready();
    cycles(CPB);
    check("after_reset_one_byte", acc_cnt - acc_before, 1);
    check("after_reset_idle_valid", {31'd0, valid}, 32'd0);

    // back-to-back bytes at this line rate with ready held high
    ready = 1'b1;
    sb.push_back(8'h00);
    sb.push_back(8'hFF);
    sb.push_back(8'h80);
    send(8'h00, CPB, 1'b1);
    send(8'hFF, CPB, 1'b1);
    send(8'h80, CPB, 1'b1);
    cycles(5);

    // random traffic with +/-2% bit period, glitches and framing errors
    for (int n = 0; n < 30; n++) begin
      int kind;
      int bp;
      logic [7:0] b;
      kind = $urandom_range(0, 9);
      bp   = CPB - 1 + $urandom_range(0, 2);
      b    = 8'($urandom);
      if (kind < 7) begin
        sb.push_back(b);
        send(b, bp, 1'b1);
      end else if (kind < 9) begin
        send(b, bp, 1'b0);
        exp_fe++;
        drive(1'b0, $urandom_range(0, CPB));
        drive(1'b1, 3);
      end else begin
        drive(1'b0, $urandom_range(2, HALF - 5));
        drive(1'b1, CPB);
      end
      drive(1'b1, $urandom_range(0, 5));
    end
    cycles(20);
    ready = 1'b0;

    check("sb_empty_at_end", sb.size(), 0);
    check("fe_count_end", fe_cnt, exp_fe);
    check("ov_count_end", ov_cnt, exp_ov);
    summary();
    $finish;
  end

endmodule

// File: doc/enigma_uart_rx.md
# enigma_uart_rx

UART receiver for the Enigma design. It takes the raw `uart_rx` pin (8N1, LSB first) and delivers whole bytes to the Enigma core through a single-entry valid/ready holding register. It sits directly downstream of the board pin, inside `enigma_top_amd`, and feeds the command/character path. It also reports framing errors, overruns and line activity for the status LEDs.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency in Hz.
- `BAUD`, 115200, line rate in baud.
- Derived: `CLKS_PER_BIT = CLK_HZ/BAUD` (integer truncation; 868 at default), `HALF_BIT = CLKS_PER_BIT/2` (434). Counter width is `$clog2(CLKS_PER_BIT)`.

- `clk_100mhz` input 1: system clock; all logic on its rising edge.
- `ext_rst_n` input 1: reset, asynchronous and active-low.
- `uart_rx` input 1: asynchronous serial line, idle high.
- `rx_data` output 8: received byte; valid only while `rx_valid`=1.
- `rx_valid` output 1: holding register full.
- `rx_ready` input 1: consumer accepts the byte when `rx_valid` & `rx_ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped.
- `rx_busy` output 1: high whenever the FSM is not in IDLE (LED activity).

## Operation
- **Synchronizer:** two-flop synchronizer on `uart_rx`, both flops reset to 1. The FSM sees only the synchronized value `rx_s`.
- **IDLE:** bit counter and clock counter held at 0. On `rx_s`=0, go to START.
- **START:** count `HALF_BIT` cycles, then sample `rx_s`.
  - If 0: go to DATA with clock counter 0 and bit index 0.
  - If 1 (glitch/false start): return to IDLE. No output.
- **DATA:** every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit[index], LSB first. After the sample with index 7, go to STOP.
- **STOP:** after `CLKS_PER_BIT` cycles, sample `rx_s`.
  - If 1: the byte is complete. Go to IDLE.
  - If 0: pulse `frame_err`, discard the byte, go to WAIT_HIGH.
- **WAIT_HIGH:** remain until `rx_s`=1, then go to IDLE. This covers break conditions; no new start is detected until the line returns high.
- **Holding register, on byte complete:**
  - If `rx_valid`=0: load `rx_data`, set `rx_valid`.
  - If `rx_valid`=1 and `rx_ready`=1 in the same cycle: the old byte is accepted, the new byte is loaded, and `rx_valid` stays 1.
  - If `rx_valid`=1 and `rx_ready`=0: pulse `overrun`, drop the new byte, keep the old one unchanged.
- **Accept without completion:** `rx_valid` & `rx_ready` with no byte completing clears `rx_valid` on the next edge. `rx_data` holds its last value.
- **Reset:** reset at any time, including mid-frame, aborts the frame. The FSM returns to IDLE and the next clean start bit is received normally.

## Timing
- **Reset values:** `rx_data`=0x00, `rx_valid`=0, `frame_err`=0, `overrun`=0, `rx_busy`=0, FSM=IDLE, synchronizer=1.
- **Start detection:** 2 cycles of synchronizer delay from the pin edge to `rx_s`, plus 1 cycle to leave IDLE.
- **Sample points,** counted from the first IDLE cycle with `rx_s`=0:
  - Start check at `HALF_BIT`.
  - Data bit k at `HALF_BIT+(k+1)*CLKS_PER_BIT`.
  - Stop at `HALF_BIT+9*CLKS_PER_BIT` (8246 at default).
- **Output timing:** `rx_valid`, `frame_err` and `overrun` change on the edge following the stop sample. Pulses are exactly one cycle.
- **Next start:** a start bit arriving immediately after a good stop bit is accepted. IDLE is re-entered the cycle after the stop sample, so no idle time beyond the stop bit is required.
- **Tolerance:** accepts ±2% baud error (mid-bit sampling).
- **Handshake:** `rx_ready` may be held high continuously. Byte throughput is limited only by the line.

## Test plan
- **Single byte:** reset, then drive 0x41 at 115200 (8680 ns/bit); `rx_ready`=0. Expect `rx_valid`=1 with `rx_data`=0x41 on the edge after the stop sample. `rx_valid` drops one cycle after `rx_ready` is pulsed. `frame_err` and `overrun` stay 0.
- **Glitch rejection:** drive `uart_rx` low for 200 cycles, then high. Expect FSM back to IDLE after the start check, `rx_busy` low, no `rx_valid`. Then send 0xA5 and expect 0xA5.
- **Framing error:** send 0x3C with the stop bit low, holding the line low for a further 2 bit times. Expect a one-cycle `frame_err`, no `rx_valid`, and the FSM in WAIT_HIGH until the line rises. Then send 0x5A and expect 0x5A.
- **Overrun and simultaneity:**
  - Send 0x11 then 0x22 back-to-back with `rx_ready`=0. Expect `rx_data`=0x11 held and one `overrun` pulse.
  - Repeat with `rx_ready`=1 asserted exactly on the 0x22 completion cycle. Expect `rx_data`=0x22, `rx_valid` continuously high, no `overrun`.
- **Reset mid-frame:** assert `ext_rst_n`=0 during data bit 4 of 0xFF. Expect all outputs at their reset values immediately (asynchronous). After release, send 0x07 and expect exactly one byte 0x07.
- **Parameter check:** `CLK_HZ`=50_000_000, `BAUD`=1_000_000 (`CLKS_PER_BIT`=50). Send 0x00, 0xFF and 0x80 back-to-back and expect all three, in order, with `rx_ready`=1.
